// File: rtl/mp_add_seq.sv
// Multi-precision adder/subtractor: walks W-bit operands one N-bit word per cycle
// through an external combinational N-bit adder, chaining the carry between words.
module mp_add_seq #(
   parameter int unsigned W = 64,
   parameter int unsigned N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         sub,
   input  logic         cin,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic [N-1:0] add_a,
   output logic [N-1:0] add_b,
   output logic         add_cin,
   input  logic [N-1:0] add_s,
   input  logic         add_cout
);

   localparam int unsigned WORDS = W / N;
   localparam int unsigned KW    = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [KW-1:0] k;
   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;
   logic [W-1:0]  b_eff;
   logic          sub_reg;
   logic          carry_reg;
   logic          last_word;
   int unsigned   base;

   assign last_word = (k == KW'(WORDS - 1));
   assign base      = 32'(k) * N;
   assign b_eff     = sub_reg ? ~b_reg : b_reg;

   // State register; busy/done are registered decodes of the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
         done  <= (state_nxt == DONE);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_word) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Adder word select; idle/done cycles present zeros to the external adder
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (state == RUN) begin
         add_a   = N'(a_reg >> base);
         add_b   = N'(b_eff >> base);
         add_cin = carry_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         sub_reg   <= 1'b0;
         carry_reg <= 1'b0;
         k         <= '0;
         sum       <= '0;
         cout      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg     <= op_a;
                  b_reg     <= op_b;
                  sub_reg   <= sub;
                  // Subtract is A + ~B + 1, so the carry chain is seeded with 1
                  carry_reg <= sub | cin;
                  k         <= '0;
                  sum       <= '0;
                  cout      <= 1'b0;
               end
            end
            RUN: begin
               sum[base +: N] <= add_s;
               carry_reg      <= add_cout;
               k              <= last_word ? '0 : k + KW'(1);
               if (last_word) cout <= add_cout;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq: directed corner cases, back-to-back start storm, reset abort,
// and a random add/sub regression against a plain-arithmetic reference.
module tb_mp_add_seq;

   localparam int unsigned W     = 64;
   localparam int unsigned N     = 16;
   localparam int unsigned WORDS = W / N;

   logic         clk;
   logic         rst;
   logic         start;
   logic         sub;
   logic         cin;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic [N-1:0] add_a;
   logic [N-1:0] add_b;
   logic         add_cin;
   logic [N-1:0] add_s;
   logic         add_cout;

   int n_checks = 0;
   int n_fail   = 0;

   mp_add_seq #(.W(W), .N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
      .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .sum(sum), .cout(cout),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout)
   );

   // External N-bit adder
   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + (N + 1)'(add_cin);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W:0] ref_op(input bit s, input bit c, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
      if (s) return {(a >= b) ? 1'b1 : 1'b0, a - b};
      return {1'b0, a} + {1'b0, b} + (W + 1)'(c);
   endfunction

   function automatic logic [W-1:0] rnd64();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return W'(64'(1) << $urandom_range(0, W - 1));
         default: return {$urandom(), $urandom()};
      endcase
   endfunction

   // One full operation; operands are scrambled right after acceptance
   task automatic run_op(input bit s, input bit c, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] got_sum, output logic got_cout,
                         output logic [WORDS-1:0] cins);
      logic [W:0] exp;
      exp = ref_op(s, c, a, b);
      @(negedge clk);
      start = 1'b1; sub = s; cin = c; op_a = a; op_b = b;
      for (int i = 0; i < int'(WORDS); i++) begin
         @(negedge clk);
         if (i == 0) begin
            start = 1'b0; sub = ~s; cin = ~c; op_a = rnd64(); op_b = rnd64();
         end
         cins[i] = add_cin;
         if (done !== 1'b0) check("done_early", 128'(done), 128'(0));
      end
      @(negedge clk);
      check("done_latency", 128'(done), 128'(1));
      check("busy_in_done", 128'(busy), 128'(1));
      check("sum", 128'(sum), 128'(exp[W-1:0]));
      check("cout", 128'(cout), 128'(exp[W]));
      if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0)
         check("adder_idle", 128'({add_a, add_b, add_cin}), 128'(0));
      got_sum  = sum;
      got_cout = cout;
      @(negedge clk);
      check("done_pulse", 128'({busy, done}), 128'(0));
      check("sum_hold", 128'({cout, sum}), 128'(exp));
   endtask

   logic [W-1:0]     r_sum;
   logic             r_cout;
   logic [WORDS-1:0] r_cins;
   logic [W:0]       expq[$];
   logic [W:0]       e;
   int               cnt;
   int               n_acc;
   int               n_done;
   bit               s;
   bit               c;

   initial begin
      rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
      repeat (2) @(negedge clk);
      start = 1'b1; op_a = '1; op_b = '1;
      @(negedge clk);
      check("reset_state", 128'({busy, done, cout, sum}), 128'(0));
      check("reset_adder", 128'({add_a, add_b, add_cin}), 128'(0));
      rst = 1'b0; start = 1'b0;

      // Carry ripple through every word
      run_op(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, r_sum, r_cout, r_cins);
      check("ripple_sum", 128'(r_sum), 128'(0));
      check("ripple_cout", 128'(r_cout), 128'(1));
      check("ripple_cins", 128'(r_cins), 128'(4'b1110));

      run_op(1'b1, 1'b0, 64'h0000_0000_0001_0000, 64'h1, r_sum, r_cout, r_cins);
      check("borrow_sum", 128'(r_sum), 128'(64'h0000_0000_0000_FFFF));
      check("borrow_cout", 128'(r_cout), 128'(1));
      run_op(1'b1, 1'b1, 64'h0, 64'h1, r_sum, r_cout, r_cins);
      check("under_sum", 128'(r_sum), 128'(64'hFFFF_FFFF_FFFF_FFFF));
      check("under_cout", 128'(r_cout), 128'(0));
      run_op(1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, r_sum, r_cout, r_cins);
      check("mixed_sum", 128'(r_sum), 128'(64'h2222_2222_2222_2212));
      check("mixed_cout", 128'(r_cout), 128'(0));

      // Start asserted every cycle: only idle cycles accept
      cnt = 0; n_acc = 0; n_done = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         check("storm_busy", 128'(busy), 128'(cnt > 0));
         check("storm_done", 128'(done), 128'(cnt == 1));
         if (done === 1'b1) begin
            n_done++;
            if (expq.size() > 0) begin
               e = expq.pop_front();
               check("storm_result", 128'({cout, sum}), 128'(e));
            end else check("storm_extra_done", 128'(1), 128'(0));
         end
         if (i < 20) begin
            start = 1'b1; sub = 1'($urandom()); cin = 1'($urandom());
            op_a = rnd64(); op_b = rnd64();
         end else start = 1'b0;
         if (cnt == 0 && start) begin
            expq.push_back(ref_op(sub, cin, op_a, op_b));
            n_acc++;
            cnt = WORDS + 1;
         end else if (cnt > 0) cnt--;
         if (cnt == int'(WORDS + 1) && start == 1'b0) cnt = cnt;
      end
      check("storm_accepts", 128'(n_done), 128'(n_acc));
      check("storm_queue", 128'(expq.size()), 128'(0));

      // Reset in the middle of an operation
      @(negedge clk);
      start = 1'b1; sub = 1'b0; cin = 1'b0; op_a = '1; op_b = '1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_state", 128'({busy, done, cout, sum}), 128'(0));
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) check("abort_quiet", 128'({busy, done}), 128'(0));
      end
      run_op(1'b0, 1'b0, 64'd3, 64'd4, r_sum, r_cout, r_cins);
      check("after_abort_sum", 128'(r_sum), 128'(7));

      // Random regression
      for (int i = 0; i < 5000; i++) begin
         s = 1'b0; c = 1'($urandom());
         run_op(s, c, rnd64(), rnd64(), r_sum, r_cout, r_cins);
         s = 1'b1;
         run_op(s, c, rnd64(), rnd64(), r_sum, r_cout, r_cins);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
